// File: rtl/icache_refill_ctrl.sv
// Refill sequencer for the single-port icache data array: assembles memory beats
// into a full line, writes it back, and arbitrates the port with IFU fetch reads.
module icache_refill_ctrl #(
    parameter int ICACHE_DATA_WIDTH  = 256,
    parameter int ICACHE_INDEX_WIDTH = 6,
    parameter int MEM_DATA_WIDTH     = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ifu_req_valid_i,
    output logic                          ifu_req_ready_o,
    input  logic [ICACHE_INDEX_WIDTH-1:0] ifu_req_index_i,
    output logic                          ifu_rsp_valid_o,
    output logic [ICACHE_DATA_WIDTH-1:0]  ifu_rsp_data_o,
    input  logic                          refill_req_valid_i,
    output logic                          refill_req_ready_o,
    input  logic [ICACHE_INDEX_WIDTH-1:0] refill_req_index_i,
    output logic                          refill_done_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [ICACHE_INDEX_WIDTH-1:0] mem_req_index_o,
    input  logic                          mem_rsp_valid_i,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_rsp_data_i,
    output logic [ICACHE_INDEX_WIDTH-1:0] icache_index_o,
    output logic [ICACHE_DATA_WIDTH-1:0]  icache_wdata_o,
    output logic                          icache_wen_o,
    input  logic [ICACHE_DATA_WIDTH-1:0]  icache_rdata_i
);

    localparam int BEATS = ICACHE_DATA_WIDTH / MEM_DATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEM_REQ = 2'd1;
    localparam logic [1:0] FILL    = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [CNT_W-1:0]              beatCnt_q, beatCnt_d;
    logic [ICACHE_INDEX_WIDTH-1:0] refillIdx_q, refillIdx_d;
    logic [ICACHE_DATA_WIDTH-1:0]  lineBuf_q, lineBuf_d;
    logic                          ifuRspValid_q, ifuRspValid_d;
    logic                          ifuReady;
    logic                          refillReady;

    assign refillReady = rst_i && (state_q == IDLE);

    // A fetch must not read a set whose line is mid-refill, including one being
    // accepted this very cycle, and the array port belongs to the write in WRITE.
    always_comb begin
        ifuReady = 1'b1;
        if (!rst_i) begin
            ifuReady = 1'b0;
        end else begin
            case (state_q)
                WRITE:         ifuReady = 1'b0;
                MEM_REQ, FILL: if (ifu_req_index_i == refillIdx_q) ifuReady = 1'b0;
                IDLE:          if (refill_req_valid_i && (ifu_req_index_i == refill_req_index_i)) ifuReady = 1'b0;
                default:       ifuReady = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        beatCnt_d     = beatCnt_q;
        refillIdx_d   = refillIdx_q;
        lineBuf_d     = lineBuf_q;
        ifuRspValid_d = ifu_req_valid_i && ifuReady;
        case (state_q)
            IDLE: begin
                if (refill_req_valid_i && refillReady) begin
                    refillIdx_d = refill_req_index_i;
                    state_d     = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_req_ready_i) begin
                    beatCnt_d = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (mem_rsp_valid_i) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beatCnt_q == CNT_W'(k)) begin
                            lineBuf_d[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rsp_data_i;
                        end
                    end
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                    if (beatCnt_q == CNT_W'(BEATS-1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            beatCnt_q     <= '0;
            refillIdx_q   <= '0;
            lineBuf_q     <= '0;
            ifuRspValid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beatCnt_q     <= beatCnt_d;
            refillIdx_q   <= refillIdx_d;
            lineBuf_q     <= lineBuf_d;
            ifuRspValid_q <= ifuRspValid_d;
        end
    end

    assign ifu_req_ready_o    = ifuReady;
    assign ifu_rsp_valid_o    = ifuRspValid_q;
    assign ifu_rsp_data_o     = icache_rdata_i;
    assign refill_req_ready_o = refillReady;
    assign refill_done_o      = (state_q == WRITE);
    assign mem_req_valid_o    = (state_q == MEM_REQ);
    assign mem_req_index_o    = refillIdx_q;
    assign icache_wen_o       = (state_q == WRITE);
    assign icache_index_o     = (state_q == WRITE) ? refillIdx_q : ifu_req_index_i;
    assign icache_wdata_o     = lineBuf_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a behavioural data array plus a
// per-set line model predict every fetch response and refill write.
module tb_icache_refill_ctrl;

    logic         clk;
    logic         rst_i;
    logic         ifu_req_valid_i;
    logic         ifu_req_ready_o;
    logic [5:0]   ifu_req_index_i;
    logic         ifu_rsp_valid_o;
    logic [255:0] ifu_rsp_data_o;
    logic         refill_req_valid_i;
    logic         refill_req_ready_o;
    logic [5:0]   refill_req_index_i;
    logic         refill_done_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [5:0]   mem_req_index_o;
    logic         mem_rsp_valid_i;
    logic [63:0]  mem_rsp_data_i;
    logic [5:0]   icache_index_o;
    logic [255:0] icache_wdata_o;
    logic         icache_wen_o;
    logic [255:0] icache_rdata_i;

    int testsRun    = 0;
    int testsFailed = 0;

    // Array contents as the DUT should see them, plus observed write/done counts.
    logic [255:0] arr [64];
    bit           arrValid [64];
    int           wrCount   = 0;
    int           doneCount = 0;

    // What the bench believes each set holds, updated only when a refill completes.
    logic [255:0] modelLine [64];
    bit           modelWritten [64];

    icache_refill_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .ifu_req_valid_i    (ifu_req_valid_i),
        .ifu_req_ready_o    (ifu_req_ready_o),
        .ifu_req_index_i    (ifu_req_index_i),
        .ifu_rsp_valid_o    (ifu_rsp_valid_o),
        .ifu_rsp_data_o     (ifu_rsp_data_o),
        .refill_req_valid_i (refill_req_valid_i),
        .refill_req_ready_o (refill_req_ready_o),
        .refill_req_index_i (refill_req_index_i),
        .refill_done_o      (refill_done_o),
        .mem_req_valid_o    (mem_req_valid_o),
        .mem_req_ready_i    (mem_req_ready_i),
        .mem_req_index_o    (mem_req_index_o),
        .mem_rsp_valid_i    (mem_rsp_valid_i),
        .mem_rsp_data_i     (mem_rsp_data_i),
        .icache_index_o     (icache_index_o),
        .icache_wdata_o     (icache_wdata_o),
        .icache_wen_o       (icache_wen_o),
        .icache_rdata_i     (icache_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pattern(input logic [5:0] idx);
        logic [7:0] b;
        b = {4'hA, idx[3:0]};
        return {32{b}};
    endfunction

    function automatic logic [255:0] expData(input logic [5:0] idx);
        return modelWritten[idx] ? modelLine[idx] : pattern(idx);
    endfunction

    function automatic logic [255:0] randLine();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Single-port array: writes on wen, otherwise registered read of the index.
    always @(posedge clk) begin
        if (icache_wen_o) begin
            arr[icache_index_o]      <= icache_wdata_o;
            arrValid[icache_index_o] <= 1'b1;
            wrCount                  <= wrCount + 1;
        end else begin
            icache_rdata_i <= arrValid[icache_index_o] ? arr[icache_index_o] : pattern(icache_index_o);
        end
        if (refill_done_o) doneCount <= doneCount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchCheck(input logic [5:0] idx);
        ifu_req_valid_i = 1'b1;
        ifu_req_index_i = idx;
        #1;
        testsRun++;
        if (ifu_req_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fetch_ready idx=%0d: got %b expected 1", idx, ifu_req_ready_o);
        end
        tick();
        ifu_req_valid_i = 1'b0;
        testsRun++;
        if (ifu_rsp_valid_o !== 1'b1 || ifu_rsp_data_o !== expData(idx)) begin
            testsFailed++;
            $display("[TB] FAIL fetch_rsp idx=%0d: got v=%b %h expected v=1 %h", idx, ifu_rsp_valid_o, ifu_rsp_data_o, expData(idx));
        end
    endtask

    task automatic acceptRefill(input logic [5:0] idx);
        refill_req_valid_i = 1'b1;
        refill_req_index_i = idx;
        #1;
        testsRun++;
        if (refill_req_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL refill_ready: got %b expected 1", refill_req_ready_o);
        end
        tick();
        refill_req_valid_i = 1'b0;
        testsRun++;
        if (mem_req_valid_o !== 1'b1 || mem_req_index_o !== idx) begin
            testsFailed++;
            $display("[TB] FAIL mem_req: got v=%b idx=%0d expected v=1 idx=%0d", mem_req_valid_o, mem_req_index_o, idx);
        end
    endtask

    task automatic memGrant(input int delay, input bit junk);
        for (int i = 0; i < delay; i++) begin
            mem_rsp_valid_i = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rsp_data_i  = {$urandom, $urandom};
            tick();
            testsRun++;
            if (mem_req_valid_o !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL mem_req_hold: got %b expected 1", mem_req_valid_o);
            end
        end
        mem_rsp_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        testsRun++;
        if (mem_req_valid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mem_req_drop: got %b expected 0", mem_req_valid_o);
        end
    endtask

    task automatic sendBeat(input logic [63:0] d, input int gap);
        for (int i = 0; i < gap; i++) begin
            mem_rsp_valid_i = 1'b0;
            tick();
            testsRun++;
            if (icache_wen_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL early_write: got %b expected 0", icache_wen_o);
            end
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        tick();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic checkWrite(input logic [5:0] idx, input logic [255:0] line);
        int w0;
        int d0;
        testsRun++;
        if (icache_wen_o !== 1'b1 || refill_done_o !== 1'b1 || icache_index_o !== idx || icache_wdata_o !== line) begin
            testsFailed++;
            $display("[TB] FAIL write_cycle: got wen=%b done=%b idx=%0d data=%h expected wen=1 done=1 idx=%0d data=%h",
                     icache_wen_o, refill_done_o, icache_index_o, icache_wdata_o, idx, line);
        end
        testsRun++;
        if (ifu_req_ready_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_ifu_ready: got %b expected 0", ifu_req_ready_o);
        end
        w0 = wrCount;
        d0 = doneCount;
        tick();
        testsRun++;
        if (icache_wen_o !== 1'b0 || refill_done_o !== 1'b0 || wrCount != w0 + 1 || doneCount != d0 + 1 || refill_req_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL write_once: got wen=%b done=%b writes=%0d pulses=%0d ready=%b expected 0 0 %0d %0d 1",
                     icache_wen_o, refill_done_o, wrCount - w0, doneCount - d0, refill_req_ready_o, 1, 1);
        end
        modelLine[idx]    = line;
        modelWritten[idx] = 1'b1;
    endtask

    task automatic fullRefill(input logic [5:0] idx, input logic [255:0] line, input int delay, input int maxGap, input bit junk);
        acceptRefill(idx);
        memGrant(delay, junk);
        for (int k = 0; k < 4; k++) sendBeat(line[k*64 +: 64], $urandom_range(0, maxGap));
        checkWrite(idx, line);
    endtask

    task automatic test_reset();
        rst_i              = 1'b0;
        ifu_req_valid_i    = 1'b0;
        ifu_req_index_i    = '0;
        refill_req_valid_i = 1'b0;
        refill_req_index_i = '0;
        mem_req_ready_i    = 1'b0;
        mem_rsp_valid_i    = 1'b0;
        mem_rsp_data_i     = '0;
        tick();
        tick();
        testsRun++;
        if (ifu_rsp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || refill_done_o !== 1'b0 || icache_wen_o !== 1'b0 || ifu_req_ready_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got rsp=%b mem=%b done=%b wen=%b ifu_ready=%b expected all 0",
                     ifu_rsp_valid_o, mem_req_valid_o, refill_done_o, icache_wen_o, ifu_req_ready_o);
        end
        rst_i = 1'b1;
        #1;
        testsRun++;
        if (ifu_req_ready_o !== 1'b1 || refill_req_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got ifu_ready=%b refill_ready=%b expected 1 1", ifu_req_ready_o, refill_req_ready_o);
        end
        tick();
    endtask

    task automatic test_fetch();
        fetchCheck(6'd5);
        tick();
        testsRun++;
        if (ifu_rsp_valid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fetch_idle: got %b expected 0", ifu_rsp_valid_o);
        end
        ifu_req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifu_req_index_i = 6'(5 + i);
            tick();
            testsRun++;
            if (ifu_rsp_valid_o !== 1'b1 || ifu_rsp_data_o !== expData(6'(5 + i))) begin
                testsFailed++;
                $display("[TB] FAIL fetch_b2b idx=%0d: got v=%b %h expected v=1 %h", 5 + i, ifu_rsp_valid_o, ifu_rsp_data_o, expData(6'(5 + i)));
            end
        end
        for (int i = 0; i < 10; i++) begin
            logic       v;
            logic [5:0] idx;
            v               = 1'($urandom_range(0, 1));
            idx             = 6'($urandom);
            ifu_req_valid_i = v;
            ifu_req_index_i = idx;
            tick();
            testsRun++;
            if (ifu_rsp_valid_o !== v || (v && ifu_rsp_data_o !== expData(idx))) begin
                testsFailed++;
                $display("[TB] FAIL fetch_rand idx=%0d: got v=%b %h expected v=%b %h", idx, ifu_rsp_valid_o, ifu_rsp_data_o, v, expData(idx));
            end
        end
        ifu_req_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_refill_basic();
        logic [255:0] line;
        line = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        ifu_req_valid_i = 1'b0;
        ifu_req_index_i = 6'd3;
        fullRefill(6'd12, line, 3, 2, 1'b0);
        fetchCheck(6'd12);
    endtask

    task automatic test_fetch_hazard();
        logic [255:0] line;
        line = randLine();
        acceptRefill(6'd12);
        memGrant(1, 1'b0);
        sendBeat(line[63:0], 0);
        ifu_req_valid_i = 1'b1;
        ifu_req_index_i = 6'd12;
        #1;
        testsRun++;
        if (ifu_req_ready_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hazard_same_set: got %b expected 0", ifu_req_ready_o);
        end
        fetchCheck(6'd3);
        ifu_req_valid_i = 1'b1;
        ifu_req_index_i = 6'd12;
        for (int k = 1; k < 4; k++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = line[k*64 +: 64];
            #1;
            testsRun++;
            if (ifu_req_ready_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL hazard_stall beat=%0d: got %b expected 0", k, ifu_req_ready_o);
            end
            tick();
            testsRun++;
            if (ifu_rsp_valid_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL hazard_no_rsp beat=%0d: got %b expected 0", k, ifu_rsp_valid_o);
            end
        end
        mem_rsp_valid_i = 1'b0;
        checkWrite(6'd12, line);
        fetchCheck(6'd12);
    endtask

    task automatic test_simultaneous();
        logic [255:0] line1;
        logic [255:0] line2;
        line1 = randLine();
        line2 = randLine();
        refill_req_valid_i = 1'b1;
        refill_req_index_i = 6'd9;
        ifu_req_valid_i    = 1'b1;
        ifu_req_index_i    = 6'd9;
        #1;
        testsRun++;
        if (ifu_req_ready_o !== 1'b0 || refill_req_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL simul_same: got ifu_ready=%b refill_ready=%b expected 0 1", ifu_req_ready_o, refill_req_ready_o);
        end
        tick();
        refill_req_valid_i = 1'b0;
        testsRun++;
        if (ifu_rsp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b1 || mem_req_index_o !== 6'd9 || ifu_req_ready_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL simul_same_after: got rsp=%b mem=%b idx=%0d ifu_ready=%b expected 0 1 9 0",
                     ifu_rsp_valid_o, mem_req_valid_o, mem_req_index_o, ifu_req_ready_o);
        end
        ifu_req_valid_i = 1'b0;
        memGrant(2, 1'b1);
        for (int k = 0; k < 4; k++) sendBeat(line1[k*64 +: 64], $urandom_range(0, 1));
        checkWrite(6'd9, line1);

        refill_req_valid_i = 1'b1;
        refill_req_index_i = 6'd9;
        ifu_req_valid_i    = 1'b1;
        ifu_req_index_i    = 6'd4;
        #1;
        testsRun++;
        if (ifu_req_ready_o !== 1'b1 || refill_req_ready_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL simul_diff: got ifu_ready=%b refill_ready=%b expected 1 1", ifu_req_ready_o, refill_req_ready_o);
        end
        tick();
        refill_req_valid_i = 1'b0;
        ifu_req_valid_i    = 1'b0;
        testsRun++;
        if (ifu_rsp_valid_o !== 1'b1 || ifu_rsp_data_o !== expData(6'd4) || mem_req_valid_o !== 1'b1 || mem_req_index_o !== 6'd9) begin
            testsFailed++;
            $display("[TB] FAIL simul_diff_after: got rsp=%b data=%h mem=%b idx=%0d expected 1 %h 1 9",
                     ifu_rsp_valid_o, ifu_rsp_data_o, mem_req_valid_o, mem_req_index_o, expData(6'd4));
        end
        memGrant(1, 1'b0);
        for (int k = 0; k < 4; k++) sendBeat(line2[k*64 +: 64], $urandom_range(0, 2));
        checkWrite(6'd9, line2);
        fetchCheck(6'd9);
    endtask

    task automatic test_reset_mid();
        logic [255:0] line;
        logic [255:0] line2;
        int           w0;
        int           d0;
        line  = randLine();
        line2 = randLine();
        acceptRefill(6'd20);
        memGrant(1, 1'b0);
        sendBeat(line[63:0], 0);
        sendBeat(line[127:64], 1);
        rst_i = 1'b0;
        tick();
        testsRun++;
        if (mem_req_valid_o !== 1'b0 || icache_wen_o !== 1'b0 || refill_done_o !== 1'b0 || ifu_rsp_valid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got mem=%b wen=%b done=%b rsp=%b expected all 0",
                     mem_req_valid_o, icache_wen_o, refill_done_o, ifu_rsp_valid_o);
        end
        rst_i = 1'b1;
        w0 = wrCount;
        d0 = doneCount;
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = {$urandom, $urandom};
            tick();
            mem_rsp_valid_i = 1'b0;
            tick();
        end
        testsRun++;
        if (wrCount != w0 || doneCount != d0 || refill_req_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stray_beats: got writes=%0d pulses=%0d ready=%b mem=%b expected 0 0 1 0",
                     wrCount - w0, doneCount - d0, refill_req_ready_o, mem_req_valid_o);
        end
        fullRefill(6'd1, line2, 0, 1, 1'b0);
        fetchCheck(6'd20);
        fetchCheck(6'd1);
    endtask

    task automatic test_random_refills();
        for (int n = 0; n < 6; n++) begin
            logic [5:0]   idx;
            logic [255:0] line;
            idx  = 6'($urandom);
            line = randLine();
            fullRefill(idx, line, $urandom_range(0, 3), 2, 1'b1);
            fetchCheck(idx);
            fetchCheck(6'($urandom));
        end
    endtask

    initial begin
        #100000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            modelLine[i]    = '0;
            modelWritten[i] = 1'b0;
        end
        test_reset();
        test_fetch();
        test_refill_basic();
        test_fetch_hazard();
        test_simultaneous();
        test_reset_mid();
        test_random_refills();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
